// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Optional macro UART_RX_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Returns 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line plus received-byte strobes between the pad-side receiver and user logic.
interface uart_receiver_if;
  logic       RxD;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (input RxD, output data, valid, frame_err, parity_err, busy);
  modport slave  (output RxD, input data, valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_baud_tick.sv
// Bit-period counter for the receiver: half-bit tick for start alignment, full-bit tick for sampling.
module uart_rx_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == FULL_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign half_tick = (cnt == HALF_LAST);
  assign full_tick = (cnt == FULL_LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 frame recovery from an asynchronous RxD line with 1-cycle result strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input logic             clk,
  input logic             rst,
  uart_receiver_if.master bus
);

  rx_state_t  state, state_next;
  logic       rx_p0, rx_s;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] data_hold;
  logic       valid_pulse, ferr_pulse, perr_pulse;
  logic       valid_next, ferr_next, perr_next;
  logic       baud_clr, bit_clr, shift_en;
  logic       half_tick, full_tick;
`ifdef UART_RX_PARITY_EN
  logic       pbit;
  logic       pbit_load;
`endif

  uart_rx_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clr       (baud_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_clr   = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    perr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbit_load  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        baud_clr = 1'b1;
        if (!rx_s) begin
          state_next = ST_START;
          bit_clr    = 1'b1;
        end
      end
      // Restarting the counter here puts every later full tick at a bit centre.
      ST_START: begin
        if (half_tick) begin
          baud_clr   = 1'b1;
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (full_tick) begin
          pbit_load  = 1'b1;
          state_next = ST_STOP;
        end
      end
`endif
      // Leaving at the stop-bit centre lets a following start edge be caught with no idle gap.
      ST_STOP: begin
        if (full_tick) begin
          if (!rx_s) begin
            ferr_next  = 1'b1;
            state_next = ST_BREAK;
          end else begin
            state_next = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (even_parity(shreg) ^ pbit) begin
              perr_next = 1'b1;
            end else begin
              valid_next = 1'b1;
            end
`else
            valid_next = 1'b1;
`endif
          end
        end
      end
      ST_BREAK: begin
        baud_clr = 1'b1;
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0       <= 1'b1;
      rx_s        <= 1'b1;
      bit_cnt     <= 3'd0;
      data_hold   <= 8'h00;
      valid_pulse <= 1'b0;
      ferr_pulse  <= 1'b0;
      perr_pulse  <= 1'b0;
    end else begin
      rx_p0       <= bus.RxD;
      rx_s        <= rx_p0;
      valid_pulse <= valid_next;
      ferr_pulse  <= ferr_next;
      perr_pulse  <= perr_next;
      if (bit_clr) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (valid_next) begin
        data_hold <= shreg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      shreg <= {rx_s, shreg[7:1]};
    end
`ifdef UART_RX_PARITY_EN
    if (pbit_load) begin
      pbit <= rx_s;
    end
`endif
  end

  assign bus.data      = data_hold;
  assign bus.valid     = valid_pulse;
  assign bus.frame_err = ferr_pulse;
  assign bus.busy      = (state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_pulse;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
